pipo_load_arbiter: RTL and testbench

- Round-robin arbiter that shares one external PIPO register (load / parallel_in / parallel_out) among NUM_REQ requesters.
- Each grant is sequenced through three steps:
  - latch the winner's data;
  - pulse the PIPO load for one cycle;
  - read back parallel_out, compare it, and acknowledge the requester.
- The block sits between the requesting engines and the PIPO instance. It is the only driver of the PIPO load and data inputs.

---
 rtl/pipo_load_arbiter.sv | 129 ++++++++++++
 tb/tb_pipo_load_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that time-shares one external PIPO register among NUM_REQ engines.
// Each grant runs IDLE -> LOAD (one-cycle load pulse) -> VERIFY (readback, ack) -> IDLE.
module pipo_load_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     pipo_load,
    output logic [WIDTH-1:0]         pipo_data,
    input  logic [WIDTH-1:0]         pipo_q,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     verify_err,
    output logic [CNT_W-1:0]         xfer_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               load_q;
    logic [WIDTH-1:0]   data_q;
    logic [ID_W-1:0]    grant_id_q;
    logic               busy_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [WIDTH-1:0]   win_data;
    logic [ID_W-1:0]    ptr_d;
    int                 idx;

    // Search starts at ptr_q and wraps, so the last winner has lowest priority next round.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_data  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
                win_data  = req_data[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d = grant_id_q + 1'b1;
        if (int'(grant_id_q) == NUM_REQ - 1) begin
            ptr_d = '0;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            ack_q      <= '0;
            load_q     <= 1'b0;
            data_q     <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        grant_id_q <= win_id;
                        data_q     <= win_data;
                        load_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    ack_q   <= NUM_REQ'(1) << grant_id_q;
                    state_q <= VERIFY;
                end
                VERIFY: begin
                    // The PIPO captured data_q on the edge that entered this state.
                    if (pipo_q != data_q) begin
                        err_q <= 1'b1;
                    end
                    cnt_q   <= cnt_q + 1'b1;
                    ptr_q   <= ptr_d;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    load_q  <= 1'b0;
                    ack_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign pipo_load  = load_q;
    assign pipo_data  = data_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign verify_err = err_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter with a behavioural PIPO register on the far side.
module tb_pipo_load_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 16;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           pipo_load;
    logic [W-1:0]   pipo_data;
    logic [W-1:0]   pipo_q;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           verify_err;
    logic [CW-1:0]  xfer_count;

    logic [W-1:0]   pipo_reg;
    logic           force_bad;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pipo_load_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .pipo_load  (pipo_load),
        .pipo_data  (pipo_data),
        .pipo_q     (pipo_q),
        .grant_id   (grant_id),
        .busy       (busy),
        .verify_err (verify_err),
        .xfer_count (xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External PIPO register; force_bad corrupts its readback.
    always_ff @(posedge clk) begin
        if (pipo_load) begin
            pipo_reg <= pipo_data;
        end
    end
    assign pipo_q = force_bad ? '0 : pipo_reg;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    // One full transfer: request, then drop req after the grant; returns what was observed.
    task automatic xfer(input logic [N-1:0] r, output logic [IDW-1:0] g,
                        output logic [W-1:0] d, output logic ld, output logic [N-1:0] a);
        req = r;
        tick();
        g  = grant_id;
        d  = pipo_data;
        ld = pipo_load;
        req = '0;
        tick();
        a = ack;
        tick();
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #5 reset = 1'b0;
        #1;
        if ({ack, pipo_load, pipo_data, grant_id, busy, verify_err, xfer_count} !== '0) begin
            $display("FAIL reset_outputs: got ack=%b load=%b data=%h gid=%0d busy=%b err=%b cnt=%0d, want all 0",
                     ack, pipo_load, pipo_data, grant_id, busy, verify_err, xfer_count);
            n_fail++;
        end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy !== 1'b0 || pipo_load !== 1'b0) begin
                $display("FAIL idle_quiet[%0d]: busy=%b load=%b, want 0 0", i, busy, pipo_load);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_single();
        set_data(0, 8'hCC);
        req = 4'b0001;
        tick();
        if (pipo_load !== 1'b1 || pipo_data !== 8'hCC || busy !== 1'b1 || ack !== 4'b0000 || grant_id !== 2'd0) begin
            $display("FAIL single_load: load=%b data=%h busy=%b ack=%b gid=%0d, want 1 cc 1 0000 0",
                     pipo_load, pipo_data, busy, ack, grant_id);
            n_fail++;
        end
        n_checks++;
        req = '0;
        tick();
        if (pipo_load !== 1'b0 || ack !== 4'b0001 || pipo_q !== 8'hCC) begin
            $display("FAIL single_verify: load=%b ack=%b pipo_q=%h, want 0 0001 cc", pipo_load, ack, pipo_q);
            n_fail++;
        end
        n_checks++;
        tick();
        if (ack !== 4'b0000 || busy !== 1'b0 || verify_err !== 1'b0 || xfer_count !== 16'd1) begin
            $display("FAIL single_done: ack=%b busy=%b err=%b cnt=%0d, want 0000 0 0 1",
                     ack, busy, verify_err, xfer_count);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_round_robin();
        int last_ack;
        logic [IDW-1:0] eg;
        logic [N-1:0]   ea;
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'h10 + 8'(i));
        req = 4'b1111;
        last_ack = 0;
        for (int t = 0; t < 5; t++) begin
            eg = 2'(t % 4);
            ea = 4'b0001 << (t % 4);
            tick();
            if (pipo_load !== 1'b1 || grant_id !== eg || pipo_data !== 8'h10 + 8'(t % 4) || ack !== 4'b0000) begin
                $display("FAIL rr_grant[%0d]: load=%b gid=%0d data=%h ack=%b, want 1 %0d %h 0000",
                         t, pipo_load, grant_id, pipo_data, ack, eg, 8'h10 + 8'(t % 4));
                n_fail++;
            end
            n_checks++;
            tick();
            if (ack !== ea) begin
                $display("FAIL rr_ack[%0d]: ack=%b, want %b", t, ack, ea);
                n_fail++;
            end
            n_checks++;
            if (t > 0) begin
                if (cyc - last_ack !== 3) begin
                    $display("FAIL rr_spacing[%0d]: %0d cycles between acks, want 3", t, cyc - last_ack);
                    n_fail++;
                end
                n_checks++;
            end
            last_ack = cyc;
            if (t == 4) req = '0;
            tick();
        end
        if (xfer_count !== 16'd5 || busy !== 1'b0) begin
            $display("FAIL rr_count: cnt=%0d busy=%b, want 5 0", xfer_count, busy);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_pointer_wrap();
        logic [IDW-1:0] g;
        logic [W-1:0]   d;
        logic           ld;
        logic [N-1:0]   a;
        do_reset();
        for (int i = 0; i < N; i++) set_data(i, 8'h40 + 8'(i));
        xfer(4'b1000, g, d, ld, a);
        if (g !== 2'd3 || a !== 4'b1000 || d !== 8'h43) begin
            $display("FAIL wrap_serve3: gid=%0d ack=%b data=%h, want 3 1000 43", g, a, d);
            n_fail++;
        end
        n_checks++;
        xfer(4'b1001, g, d, ld, a);
        if (g !== 2'd0 || a !== 4'b0001 || ld !== 1'b1) begin
            $display("FAIL wrap_after3: gid=%0d ack=%b load=%b, want 0 0001 1", g, a, ld);
            n_fail++;
        end
        n_checks++;
        xfer(4'b1001, g, d, ld, a);
        if (g !== 2'd3 || a !== 4'b1000) begin
            $display("FAIL wrap_then3: gid=%0d ack=%b, want 3 1000", g, a);
            n_fail++;
        end
        n_checks++;
        xfer(4'b0100, g, d, ld, a);
        xfer(4'b0011, g, d, ld, a);
        if (g !== 2'd0 || a !== 4'b0001 || d !== 8'h40) begin
            $display("FAIL wrap_from_ptr3: gid=%0d ack=%b data=%h, want 0 0001 40", g, a, d);
            n_fail++;
        end
        n_checks++;
        if (grant_id !== 2'd0 || xfer_count !== 16'd5) begin
            $display("FAIL wrap_idle_hold: gid=%0d cnt=%0d, want 0 5", grant_id, xfer_count);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_readback_error();
        logic [IDW-1:0] g;
        logic [W-1:0]   d;
        logic           ld;
        logic [N-1:0]   a;
        do_reset();
        set_data(0, 8'hAA);
        force_bad = 1'b1;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        if (verify_err !== 1'b0) begin
            $display("FAIL err_early: verify_err=%b during VERIFY, want 0", verify_err);
            n_fail++;
        end
        n_checks++;
        tick();
        if (verify_err !== 1'b1) begin
            $display("FAIL err_set: verify_err=%b, want 1", verify_err);
            n_fail++;
        end
        n_checks++;
        force_bad = 1'b0;
        set_data(1, 8'h55);
        xfer(4'b0010, g, d, ld, a);
        if (verify_err !== 1'b1 || xfer_count !== 16'd2 || d !== 8'h55) begin
            $display("FAIL err_sticky: err=%b cnt=%0d data=%h, want 1 2 55", verify_err, xfer_count, d);
            n_fail++;
        end
        n_checks++;
        do_reset();
        if (verify_err !== 1'b0) begin
            $display("FAIL err_clear: verify_err=%b after reset, want 0", verify_err);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_op();
        logic [IDW-1:0] g;
        logic [W-1:0]   d;
        logic           ld;
        logic [N-1:0]   a;
        do_reset();
        xfer(4'b0010, g, d, ld, a);
        req = 4'b0100;
        tick();
        if (pipo_load !== 1'b1 || busy !== 1'b1 || grant_id !== 2'd2) begin
            $display("FAIL mid_pre: load=%b busy=%b gid=%0d, want 1 1 2", pipo_load, busy, grant_id);
            n_fail++;
        end
        n_checks++;
        #1 reset = 1'b1;
        #1;
        if (pipo_load !== 1'b0 || busy !== 1'b0 || ack !== 4'b0000 || xfer_count !== 16'd0) begin
            $display("FAIL mid_async: load=%b busy=%b ack=%b cnt=%0d, want 0 0 0000 0",
                     pipo_load, busy, ack, xfer_count);
            n_fail++;
        end
        n_checks++;
        #1 reset = 1'b0;
        req = 4'b0110;
        tick();
        if (grant_id !== 2'd1 || pipo_load !== 1'b1 || ack !== 4'b0000) begin
            $display("FAIL mid_regrant: gid=%0d load=%b ack=%b, want 1 1 0000", grant_id, pipo_load, ack);
            n_fail++;
        end
        n_checks++;
        req = '0;
        tick();
        if (ack !== 4'b0010) begin
            $display("FAIL mid_ack: ack=%b, want 0010", ack);
            n_fail++;
        end
        n_checks++;
        tick();
        if (xfer_count !== 16'd1 || busy !== 1'b0) begin
            $display("FAIL mid_done: cnt=%0d busy=%b, want 1 0", xfer_count, busy);
            n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        req_data  = '0;
        force_bad = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_readback_error();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
